// File: rtl/substitution_seq_pkg.sv
// Shared types and constants for the Ascon substitution layer.
// Build option: define SUBST_SEQ_WIDE_EN to process 16 columns per cycle
// (4 RUN cycles). When it is undefined, 8 columns are processed per cycle
// (8 RUN cycles). Both builds give the same result bits.
package ascon_pack;

  // Ascon state. state[w] is 64-bit word w, and word 0 is the column MSB.
  typedef logic [4:0][63:0] type_state;

`ifdef SUBST_SEQ_WIDE_EN
  localparam int SLICE_COLS = 16;
`else
  localparam int SLICE_COLS = 8;
`endif
  localparam int NUM_SLICES = 64 / SLICE_COLS;
  localparam int CNT_W      = $clog2(NUM_SLICES);
  localparam int COL_W      = $clog2(SLICE_COLS);

  // Ascon 5-bit S-box, indexed by {w0,w1,w2,w3,w4}.
  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} subst_fsm_t;

endpackage

// File: rtl/substitution_seq_if.sv
// Bus between the constant-addition stage and the substitution sequencer.
interface substitution_seq_if;
  import ascon_pack::*;

  logic      start_i;
  type_state state_i;
  type_state substitution_o;
  logic      busy_o;
  logic      done_o;

  modport master (output start_i, state_i, input substitution_o, busy_o, done_o);
  modport slave  (input start_i, state_i, output substitution_o, busy_o, done_o);
endinterface

// File: rtl/substitution_seq_sbox.sv
// Single Ascon S-box. This is a purely combinational 5-bit table lookup.
module sbox
  import ascon_pack::*;
(
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);
  assign y_o = SBOX_TABLE[x_i];
endmodule

// File: rtl/substitution_seq.sv
// Sequential Ascon substitution layer. It substitutes one slice of
// SLICE_COLS columns per cycle, in place, inside the working register.
// Build option: SUBST_SEQ_WIDE_EN selects 16 columns per slice instead of 8.
module substitution_seq
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               resetb_i,
  substitution_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  subst_fsm_t       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  type_state        state_q, state_d;
  logic             done_q, done_d;

  logic [SLICE_COLS-1:0][5:0] col_idx;
  logic [SLICE_COLS-1:0][4:0] sb_in;
  logic [SLICE_COLS-1:0][4:0] sb_out;

  // Column j of the current slice is {slice counter, lane}. Gather its five bits, word 0 first.
  for (genvar c = 0; c < SLICE_COLS; c++) begin : g_col
    assign col_idx[c] = {cnt_q, COL_W'(c)};
    assign sb_in[c]   = {state_q[0][col_idx[c]], state_q[1][col_idx[c]],
                         state_q[2][col_idx[c]], state_q[3][col_idx[c]],
                         state_q[4][col_idx[c]]};
  end

  sbox u_sbox [SLICE_COLS-1:0] (
    .x_i (sb_in),
    .y_o (sb_out)
  );

  // Next-state logic: load on accept, then write one slice back per RUN cycle.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        for (int c = 0; c < SLICE_COLS; c++) begin
          state_d[0][col_idx[c]] = sb_out[c][4];
          state_d[1][col_idx[c]] = sb_out[c][3];
          state_d[2][col_idx[c]] = sb_out[c][2];
          state_d[3][col_idx[c]] = sb_out[c][1];
          state_d[4][col_idx[c]] = sb_out[c][0];
        end
        if (cnt_q == LAST_SLICE) begin
          cnt_d  = '0;
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register. Reset clears everything, so an aborted run never reports done.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign bus.substitution_o = state_q;
  assign bus.busy_o         = (fsm_q == RUN);
  assign bus.done_o         = done_q;

endmodule

// File: doc/substitution_seq.md
SUBSTITUTION_SEQ -- requirements
Module: substitution_seq

Interface
REQ-001 The block SHALL have no parameters; column throughput SHALL be fixed by the Configuration macro only.
REQ-002 clock_i  input  1  single clock, all state updates on rising edge.
REQ-003 resetb_i  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  request to substitute state_i; sampled only in IDLE.
REQ-005 state_i  input  type_state (5x64)  state from the constant-addition stage; sampled on the accepting edge.
REQ-006 substitution_o  output  type_state  substituted state, directly feeding diffusion.state_i.
REQ-007 busy_o  output  1  high while in RUN.
REQ-008 done_o  output  1  one-cycle pulse: substitution_o is complete and valid.

Function
REQ-009 Each column j (0..63) SHALL map the 5-bit value {state[0][j],state[1][j],state[2][j],state[3][j],state[4][j]} (word 0 = MSB) through the Ascon S-box.
REQ-010 S-box table, inputs 0x00..0x1F: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
REQ-011 FSM states SHALL be IDLE and RUN; reset state IDLE.
REQ-012 IDLE with start_i=1 at edge k: state_i SHALL be loaded into the working register, slice counter cleared, FSM -> RUN.
REQ-013 In RUN, each edge SHALL substitute one slice of C columns in place, C=8 by default: slice s covers columns 8s..8s+7, processed in ascending s.
REQ-014 Slice counter width SHALL be log2(64/C); terminal value 64/C-1; wrap to 0 on completion.
REQ-015 On the edge processing the last slice (k+8 by default), FSM -> IDLE, done_o=1 for exactly the following cycle.
REQ-016 substitution_o SHALL equal the working register at all times; its value SHALL only be guaranteed valid while done_o=1 or in IDLE after a completed run.
REQ-017 start_i in RUN SHALL be ignored, with no effect on counter, data or done_o.
REQ-018 start_i=1 in the cycle done_o=1 SHALL be accepted (FSM is IDLE), giving back-to-back runs with 9-cycle period by default.
REQ-019 substitution_o SHALL hold its result until the next accepted start_i.

Reset
REQ-020 resetb_i=0 SHALL asynchronously force IDLE, counter 0, working register all-zero, busy_o=0, done_o=0, including mid-RUN; an interrupted run SHALL never produce done_o.
REQ-021 First start_i SHALL be accepted on the first rising edge with resetb_i=1.

Configuration
REQ-022 Macro SUBST_SEQ_WIDE_EN: defined -> C=16, counter 2 bits, 4 RUN cycles, done_o at k+4; undefined -> C=8, counter 3 bits, 8 RUN cycles, done_o at k+8.
REQ-023 Results SHALL be bit-identical in both configurations.

Structure
REQ-024 ascon_pack SHALL hold type_state and the 32-entry S-box table constant; no new types local to the module.
REQ-025 Sub-module sbox (5-bit combinational lookup from the package table) SHALL be instantiated C times per slice.

Verification
REQ-026 All-zero state_i, start_i pulse -> done_o at k+8; substitution_o[2]=FFFFFFFFFFFFFFFF, words 0,1,3,4 = 0.
REQ-027 All-ones state_i -> words 0,2,3,4 = FFFFFFFFFFFFFFFF, word 1 = 0.
REQ-028 state_i = {25f7c341c45f9912, 23b794c540876856, b85451593d679610, 4fafba264a9e49ba, 62b54d5d460aded4} -> output equals software S-box model; feeding it into diffusion matches the reference round model.
REQ-029 start_i held high through RUN and during done_o -> second run starts at k+9; no glitch in done_o or counter.
REQ-030 resetb_i low at k+4 -> all outputs 0 immediately, no done_o; the next start_i completes normally.
REQ-031 Repeat REQ-026..REQ-028 with SUBST_SEQ_WIDE_EN defined -> identical data, done_o at k+4.
